// File: rtl/adder_tb_pkg.sv
// Shared types and helpers for the 2-bit adder test-vector interface.
// Holds the checker FSM encoding, default widths and the reference adder.
package adder_tb_pkg;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Full-precision {cout,sum}; callers zero-extend operands up to 32 bits.
  function automatic logic [32:0] add_ref(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        cin);
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  // Count register: clear has priority, increment stops at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= {CNT_W{1'b0}};
    end else if (clr) begin
      r_q <= {CNT_W{1'b0}};
    end else if (inc && (r_q != {CNT_W{1'b1}})) begin
      r_q <= r_q + CNT_W'(1);
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/adder_result_checker.sv
// Response monitor for the adder test-vector interface: captures each vector,
// waits a settle delay, then scores the DUT against the golden model and truth.
module adder_result_checker
  import adder_tb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] tv_a,
  input  logic [WIDTH-1:0] tv_b,
  input  logic             tv_cin,
  input  logic [WIDTH-1:0] gold_sum,
  input  logic             gold_cout,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic             gold_fault,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] fe_a,
  output logic [WIDTH-1:0] fe_b,
  output logic             fe_cin,
  output logic [WIDTH:0]   fe_exp,
  output logic [WIDTH:0]   fe_got
);

  // SETTLE state lasts SETTLE-1 cycles so sampling lands SETTLE cycles after acceptance.
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic             r_busy;
  logic             r_done;
  logic             r_mismatch;
  logic             r_gold_fault;
  logic [WIDTH-1:0] r_fe_a;
  logic [WIDTH-1:0] r_fe_b;
  logic             r_fe_cin;
  logic [WIDTH:0]   r_fe_exp;
  logic [WIDTH:0]   r_fe_got;

  logic             w_accept;
  logic             w_clr;
  logic             w_check;
  logic             w_dut_bad;
  logic             w_gold_bad;
  logic [WIDTH:0]   w_exp;
  logic [WIDTH:0]   w_got;
  logic [32:0]      w_ref;
  logic [CNT_W-1:0] w_vec_q;
  logic [CNT_W-1:0] w_err_q;

  assign w_exp      = {gold_cout, gold_sum};
  assign w_got      = {dut_cout, dut_sum};
  assign w_ref      = add_ref(32'(r_a), 32'(r_b), r_cin);
  assign w_check    = (r_state == ST_CHECK);
  assign w_dut_bad  = (w_got != w_exp);
  assign w_gold_bad = (33'(w_exp) != w_ref);

  // Next-state decode plus the vector-accept and statistics-clear strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_ARMED;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ARMED, ST_SETTLE, ST_CHECK: begin
        if (stop) begin
          w_state_nxt = ST_DONE;
        end else if (vec_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (SETTLE_LD == 4'd0) ? ST_CHECK : ST_SETTLE;
        end else if (r_state == ST_SETTLE) begin
          w_state_nxt = (r_cnt <= 4'd1) ? ST_CHECK : ST_SETTLE;
        end else if (r_state == ST_CHECK) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, settle counter, operand capture and decoded status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_cin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_SETTLE) ||
                 (w_state_nxt == ST_CHECK);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_cnt <= SETTLE_LD;
        r_a   <= tv_a;
        r_b   <= tv_b;
        r_cin <= tv_cin;
      end else if ((r_state == ST_SETTLE) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Check results: mismatch pulse, sticky golden fault, first-failure snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch   <= 1'b0;
      r_gold_fault <= 1'b0;
      r_fe_a       <= {WIDTH{1'b0}};
      r_fe_b       <= {WIDTH{1'b0}};
      r_fe_cin     <= 1'b0;
      r_fe_exp     <= {(WIDTH+1){1'b0}};
      r_fe_got     <= {(WIDTH+1){1'b0}};
    end else if (w_clr) begin
      r_mismatch   <= 1'b0;
      r_gold_fault <= 1'b0;
      r_fe_a       <= {WIDTH{1'b0}};
      r_fe_b       <= {WIDTH{1'b0}};
      r_fe_cin     <= 1'b0;
      r_fe_exp     <= {(WIDTH+1){1'b0}};
      r_fe_got     <= {(WIDTH+1){1'b0}};
    end else begin
      r_mismatch   <= w_check && w_dut_bad;
      r_gold_fault <= r_gold_fault || (w_check && w_gold_bad);
      // err_count never wraps, so zero identifies the first failure only.
      if (w_check && w_dut_bad && (w_err_q == {CNT_W{1'b0}})) begin
        r_fe_a   <= r_a;
        r_fe_b   <= r_b;
        r_fe_cin <= r_cin;
        r_fe_exp <= w_exp;
        r_fe_got <= w_got;
      end else begin
        r_fe_a   <= r_fe_a;
        r_fe_b   <= r_fe_b;
        r_fe_cin <= r_fe_cin;
        r_fe_exp <= r_fe_exp;
        r_fe_got <= r_fe_got;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_check),
    .q     (w_vec_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_check && w_dut_bad),
    .q     (w_err_q)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_done && (w_err_q == {CNT_W{1'b0}}) &&
                      (w_vec_q != {CNT_W{1'b0}}) && !r_gold_fault;
  assign mismatch   = r_mismatch;
  assign gold_fault = r_gold_fault;
  assign vec_count  = w_vec_q;
  assign err_count  = w_err_q;
  assign fe_a       = r_fe_a;
  assign fe_b       = r_fe_b;
  assign fe_cin     = r_fe_cin;
  assign fe_exp     = r_fe_exp;
  assign fe_got     = r_fe_got;

endmodule
